header_stripper: RTL and testbench

//  Receive-side counterpart of the transmit header insertion stage. Consumes one framed
//  AXI-Stream and separates each frame into three parts:
//  - payload beats, forwarded on a payload stream with TLAST on the final beat;
//  - metadata beats, forwarded on a metadata stream, or dropped;
//  - one trailing sequence-number beat, captured into a register and checked for continuity.

---
 rtl/header_stripper.sv | 142 ++++++++++++++
 tb/tb_header_stripper.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/header_stripper.sv
// Receive-side frame splitter: payload beats, metadata beats (forwarded or dropped) and one
// trailing sequence-number beat that is captured and checked for continuity.
module header_stripper #(
    parameter int DW            = 128,
    parameter int PAYLOAD_BEATS = 129,
    parameter int META_BEATS    = 3,
    parameter int SEQ_W         = 32,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DW-1:0]     s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              meta_drop,
    output logic [DW-1:0]     m_pay_tdata,
    output logic              m_pay_tvalid,
    input  logic              m_pay_tready,
    output logic              m_pay_tlast,
    output logic [DW/8-1:0]   m_pay_tkeep,
    output logic [DW-1:0]     m_meta_tdata,
    output logic              m_meta_tvalid,
    input  logic              m_meta_tready,
    output logic              m_meta_tlast,
    output logic [SEQ_W-1:0]  seq_num,
    output logic              seq_valid,
    output logic              seq_err,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [1:0]        fsm_state
);
    localparam int MAXB = (PAYLOAD_BEATS > META_BEATS) ? PAYLOAD_BEATS : META_BEATS;
    localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;

    typedef enum logic [1:0] {
        ST_PAYLOAD = 2'd0,
        ST_META    = 2'd1,
        ST_SEQ     = 2'd2
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [BW-1:0]    r_beat_cnt, w_beat_nxt;
    logic             w_acc, w_pay_last, w_meta_last;
    logic [SEQ_W-1:0] w_seq_in, w_seq_exp;
    logic [SEQ_W-1:0] r_seq_num;
    logic             r_seq_seen, r_seq_valid, r_seq_err;
    logic [CNT_W-1:0] r_frame_cnt, r_err_cnt;

    assign w_pay_last  = (r_beat_cnt == BW'(PAYLOAD_BEATS - 1));
    assign w_meta_last = (r_beat_cnt == BW'(META_BEATS - 1));
    assign w_seq_in    = s_tdata[SEQ_W-1:0];
    assign w_seq_exp   = r_seq_num + SEQ_W'(1);

    always_comb begin
        s_tready      = 1'b0;
        m_pay_tvalid  = 1'b0;
        m_pay_tdata   = '0;
        m_pay_tlast   = 1'b0;
        m_meta_tvalid = 1'b0;
        m_meta_tdata  = '0;
        m_meta_tlast  = 1'b0;
        w_state_nxt   = r_state;
        w_beat_nxt    = r_beat_cnt;
        w_acc         = 1'b0;

        // Outputs stay quiet while in reset so no beat can be handed downstream unaccepted.
        if (resetn) begin
            case (r_state)
                ST_PAYLOAD: begin
                    s_tready     = m_pay_tready;
                    m_pay_tvalid = s_tvalid;
                    m_pay_tdata  = s_tdata;
                    m_pay_tlast  = s_tvalid && w_pay_last;
                end
                ST_META: begin
                    s_tready      = meta_drop || m_meta_tready;
                    m_meta_tvalid = s_tvalid && !meta_drop;
                    m_meta_tdata  = meta_drop ? '0 : s_tdata;
                    m_meta_tlast  = s_tvalid && w_meta_last;
                end
                ST_SEQ:  s_tready = 1'b1;
                default: ;
            endcase
            w_acc = s_tvalid && s_tready;
        end

        if (w_acc) begin
            case (r_state)
                ST_PAYLOAD: begin
                    w_beat_nxt = w_pay_last ? '0 : r_beat_cnt + BW'(1);
                    if (w_pay_last) w_state_nxt = ST_META;
                end
                ST_META: begin
                    w_beat_nxt = w_meta_last ? '0 : r_beat_cnt + BW'(1);
                    if (w_meta_last) w_state_nxt = ST_SEQ;
                end
                default: begin
                    w_beat_nxt  = '0;
                    w_state_nxt = ST_PAYLOAD;
                end
            endcase
        end
    end

    assign m_pay_tkeep = {(DW/8){m_pay_tvalid}};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= ST_PAYLOAD;
            r_beat_cnt  <= '0;
            r_seq_num   <= '0;
            r_seq_seen  <= 1'b0;
            r_seq_valid <= 1'b0;
            r_seq_err   <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat_cnt  <= w_beat_nxt;
            r_seq_valid <= 1'b0;
            r_seq_err   <= 1'b0;
            if (w_acc && r_state == ST_SEQ) begin
                r_seq_num   <= w_seq_in;
                r_seq_seen  <= 1'b1;
                r_seq_valid <= 1'b1;
                r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                // The mismatching value becomes the new reference for the next frame.
                if (r_seq_seen && w_seq_in != w_seq_exp) begin
                    r_seq_err <= 1'b1;
                    if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign seq_num   = r_seq_num;
    assign seq_valid = r_seq_valid;
    assign seq_err   = r_seq_err;
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
    assign fsm_state = r_state;
endmodule

// File: tb/tb_header_stripper.sv
// Scoreboard bench for header_stripper: stimulus pushes expected beats/sequence results,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_header_stripper;
    localparam int DW = 32, PB = 4, MB = 2, SW = 32, CW = 4;

    typedef struct packed { logic [DW-1:0] d; logic last; } beat_t;
    typedef struct packed { logic [SW-1:0] num; logic err; logic [CW-1:0] fcnt; logic [CW-1:0] ecnt; } seq_t;

    logic clk = 1'b0, resetn;
    logic [DW-1:0] s_tdata;
    logic s_tvalid, s_tready, meta_drop;
    logic [DW-1:0] m_pay_tdata, m_meta_tdata;
    logic m_pay_tvalid, m_pay_tlast, m_meta_tvalid, m_meta_tlast;
    logic m_pay_tready = 1'b1, m_meta_tready = 1'b1;
    logic [DW/8-1:0] m_pay_tkeep;
    logic [SW-1:0] seq_num;
    logic seq_valid, seq_err;
    logic [CW-1:0] frame_cnt, err_cnt;
    logic [1:0] fsm_state;

    beat_t pay_q[$], meta_q[$];
    seq_t  seq_q[$];
    int checks = 0, errors = 0;
    bit done = 0, tog = 0, meta_block = 0, rnd = 0;
    int cyc = 0;
    logic rst_q = 1'b1;
    logic [CW-1:0] m_fcnt, m_ecnt;

    header_stripper #(.DW(DW), .PAYLOAD_BEATS(PB), .META_BEATS(MB), .SEQ_W(SW), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .meta_drop(meta_drop), .m_pay_tdata(m_pay_tdata), .m_pay_tvalid(m_pay_tvalid),
        .m_pay_tready(m_pay_tready), .m_pay_tlast(m_pay_tlast), .m_pay_tkeep(m_pay_tkeep),
        .m_meta_tdata(m_meta_tdata), .m_meta_tvalid(m_meta_tvalid), .m_meta_tready(m_meta_tready),
        .m_meta_tlast(m_meta_tlast), .seq_num(seq_num), .seq_valid(seq_valid), .seq_err(seq_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt), .fsm_state(fsm_state));

    always #5 clk = ~clk;

    // Downstream ready drivers: payload ready high one cycle in three while tog is set.
    always @(posedge clk) begin
        #1;
        m_pay_tready  = tog ? (cyc % 3 == 0) : 1'b1;
        m_meta_tready = !meta_block;
        cyc++;
    end

    always @(posedge clk) rst_q <= resetn;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin : monitor
        beat_t b;
        seq_t  s;
        if (done) begin
            chk("pay_q_left", 64'(pay_q.size()), 0);
            chk("meta_q_left", 64'(meta_q.size()), 0);
            chk("seq_q_left", 64'(seq_q.size()), 0);
            $display("Simulation finished: %0d checks, %0d errors", checks, errors);
            $finish;
        end
        if (m_pay_tvalid && m_pay_tready) begin
            if (pay_q.size() == 0) chk("pay_extra_beat", 64'(pay_q.size()), 1);
            else begin
                b = pay_q.pop_front();
                chk("pay_data", m_pay_tdata, b.d);
                chk("pay_last", m_pay_tlast, b.last);
                chk("pay_keep", m_pay_tkeep, 4'hF);
            end
        end
        if (m_meta_tvalid && m_meta_tready) begin
            if (meta_q.size() == 0) chk("meta_extra_beat", 64'(meta_q.size()), 1);
            else begin
                b = meta_q.pop_front();
                chk("meta_data", m_meta_tdata, b.d);
                chk("meta_last", m_meta_tlast, b.last);
            end
        end
        if (seq_valid === 1'b1) begin
            if (seq_q.size() == 0) chk("seq_extra", 64'(seq_q.size()), 1);
            else begin
                s = seq_q.pop_front();
                chk("seq_num", seq_num, s.num);
                chk("seq_err", seq_err, s.err);
                chk("frame_cnt", frame_cnt, s.fcnt);
                chk("err_cnt", err_cnt, s.ecnt);
            end
        end else if (seq_err === 1'b1) chk("seq_err_no_valid", seq_err, 0);
        if (resetn === 1'b0) chk("rst_tready", s_tready, 0);
        if (rst_q === 1'b0) begin
            chk("rst_state", fsm_state, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            chk("rst_err_cnt", err_cnt, 0);
            chk("rst_seq_num", seq_num, 0);
            chk("rst_seq_pulses", {seq_valid, seq_err}, 0);
        end
        if (resetn === 1'b1 && fsm_state == 2'd0) chk("pay_tready_follow", s_tready, m_pay_tready);
        if (resetn === 1'b1 && fsm_state == 2'd1 && meta_drop) begin
            chk("drop_meta_vld", m_meta_tvalid, 0);
            chk("drop_tready", s_tready, 1);
        end
        if (m_pay_tvalid === 1'b0) chk("pay_idle_zero", {m_pay_tdata, m_pay_tkeep}, 0);
    end

    task automatic send_beat(input logic [DW-1:0] d);
        logic acc;
        int n = 0;
        if (rnd) while ($urandom_range(0, 2) == 0) begin
            s_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        s_tdata  = d;
        s_tvalid = 1'b1;
        forever begin
            @(negedge clk); acc = s_tready;
            @(posedge clk); #1;
            if (acc) break;
            if (++n > 200) begin
                $display("FAIL beat_timeout: got no handshake expected accept of %0h", d);
                $fatal(1, "timeout");
            end
        end
        s_tvalid = 1'b0;
        s_tdata  = '0;
    endtask

    task automatic model_reset();
        m_fcnt = '0;
        m_ecnt = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();
    endtask

    task automatic send_pay(input logic [SW-1:0] sq, input int i);
        beat_t b;
        b.d = {8'hA0, 8'(i), sq[15:0]};
        b.last = (i == PB - 1);
        pay_q.push_back(b);
        send_beat(b.d);
    endtask

    // exp_err is the hand-computed continuity verdict for this frame's sequence number.
    task automatic send_frame(input logic [SW-1:0] sq, input bit exp_err);
        beat_t b;
        seq_t  s;
        for (int i = 0; i < PB; i++) send_pay(sq, i);
        for (int i = 0; i < MB; i++) begin
            b.d = {8'hB0, 8'(i), sq[15:0]};
            b.last = (i == MB - 1);
            if (!meta_drop) meta_q.push_back(b);
            send_beat(b.d);
        end
        m_fcnt = m_fcnt + 1'b1;
        if (exp_err && m_ecnt != '1) m_ecnt = m_ecnt + 1'b1;
        s.num = sq; s.err = exp_err; s.fcnt = m_fcnt; s.ecnt = m_ecnt;
        seq_q.push_back(s);
        send_beat(sq);
    endtask

    initial begin
        resetn = 1'b0; s_tvalid = 1'b0; s_tdata = '0; meta_drop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        // back-to-back frames, then a gap in the sequence
        send_frame(5, 0); send_frame(6, 0);
        send_frame(7, 0); send_frame(8, 0); send_frame(10, 1);
        // sequence wrap is continuous
        do_reset();
        send_frame(32'hFFFF_FFFF, 0); send_frame(0, 0);
        // throttled payload ready with random input gaps
        tog = 1; rnd = 1;
        send_frame(1, 0); send_frame(2, 0); send_frame(3, 0);
        tog = 0; rnd = 0;
        // metadata dropped while its downstream is stalled
        meta_drop = 1'b1; meta_block = 1;
        send_frame(4, 0); send_frame(5, 0);
        meta_drop = 1'b0; meta_block = 0;
        // reset while payload beat 2 is presented
        send_pay(50, 0); send_pay(50, 1);
        s_tdata = 32'hDEAD_0002; s_tvalid = 1'b1;
        do_reset();
        s_tvalid = 1'b0; s_tdata = '0;
        send_frame(100, 0); send_frame(101, 0);
        // error counter saturation and frame counter wrap
        do_reset();
        for (int i = 0; i < 20; i++) send_frame(SW'(i * 3), i != 0);
        repeat (3) @(posedge clk);
        done = 1;
        repeat (10) @(posedge clk);
        $display("FAIL end_timeout: got no summary expected monitor to finish");
        $fatal(1, "monitor did not finish");
    end
endmodule
